tdm_scan_demux: RTL
===================

Name: tdm_scan_demux

Overview:
- Downstream time-division stage paired with the 4:1 mux_switch.
- Drives the mux select lines round-robin and samples the single-bit mux output once per slot.
- Demultiplexes the samples back into a registered parallel word, one bit per channel, with a frame-done strobe.
- Turns the combinational mux into a serial scan link: mux data inputs are the transmit side, this block's d_out is the receive side.

Parameters:
- CH, 4, number of channels (mux data inputs); must equal 2**SEL_W.
- SEL_W, 2, select width driven to the mux.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request one scan frame; sampled only in IDLE
- continuous  input  1  1 = start the next frame immediately; sampled on the last slot of each frame
- mux_y  input  1  output of the upstream mux, combinationally dependent on sel
- sel  output  SEL_W  select lines to the mux
- busy  output  1  high while a frame is in progress
- d_out  output  CH  demultiplexed word; d_out[k] = mux_y sampled while sel==k
- frame_done  output  1  one-cycle pulse when d_out updates

Behaviour:
- Reset: all outputs and state are cleared.
  - State = IDLE; sel=0, busy=0, d_out=0, frame_done=0; shadow register cleared.
  - rst has priority over every other input.
- States: IDLE, SCAN.
- IDLE:
  - sel held at 0, busy=0.
  - start=1 at an edge -> SCAN; busy=1 from the next cycle; sel=0 in the first SCAN cycle.
- SCAN, each edge:
  - shadow[sel] <= mux_y.
  - If sel != CH-1: sel <= sel+1.
  - If sel == CH-1 (last slot):
    - d_out <= {mux_y, shadow[CH-2:0]}, so the last bit is merged directly, not via shadow.
    - frame_done <= 1 for exactly one cycle.
    - sel <= 0 (wrap).
    - continuous=1: stay in SCAN, busy stays 1, no idle gap between frames.
    - continuous=0: -> IDLE, busy <= 0 on the same edge that raises frame_done.
- Latency:
  - start sampled at edge E0.
  - Slots k=0..CH-1 are sampled at edges E(k+1).
  - d_out and frame_done are valid after edge E(CH): 4 cycles for CH=4.
- Per-frame timing:
  - Continuous mode: frame_done every CH cycles.
  - d_out holds its value between frames and is never partially updated.
- start while busy: ignored, not queued.
- Clearing continuous mid-frame: the current frame completes; the block stops after it.
- rst mid-frame:
  - Immediate return to IDLE.
  - d_out cleared, no frame_done.
  - The partial shadow is discarded.
- mux_y must be stable by the sampling edge. The mux is combinational, so slot k's data is captured in the same cycle sel==k is driven.

Optional Feature:
- Macro: TDM_CHANGE_DET_EN.
- Defined:
  - Adds output port changed (1 bit), pulsed together with frame_done when the new d_out differs from the previous d_out.
  - The first frame after reset compares against 0.
  - changed is cleared by rst.
- Undefined: no changed port and no comparison logic; all other behaviour is identical.

Test Plan:
- Single frame: bench models mux_y = i[sel] with i=4'b1010; pulse start one cycle.
  - Required: sel steps 0,1,2,3 then 0.
  - Required: frame_done pulses 4 cycles after start; d_out=4'b1010; busy falls with frame_done.
- Continuous:
  - Stimulus: continuous=1; i=4'b0110 for frame 1, then i=4'b1001 applied before frame 2 slot 0.
  - Required: frame_done every 4 cycles; d_out=0110 then 1001; no idle cycle between frames.
- Reset mid-frame:
  - Stimulus: i=4'b1111; start; assert rst when sel==2.
  - Required: next cycle sel=0, busy=0, d_out=0000, no frame_done.
  - Follow-up: a new start yields 1111.
- start while busy:
  - Stimulus: re-pulse start at sel==1, continuous=0.
  - Required: exactly one frame_done; busy low afterwards; sel idle at 0.
- Change detect (TDM_CHANGE_DET_EN defined): frames with i=0101, 0101, 0100.
  - Required: changed = 1, 0, 1 on the respective frame_done pulses.
- Parameter sweep: CH=8, SEL_W=3, i=8'hA5.
  - Required: frame_done 8 cycles after start; d_out=8'hA5.

Source files
------------

// File: rtl/tdm_scan_demux.sv
// tdm_scan_demux: receive side of a 4:1 time-division scan link.
// Drives the upstream mux select round-robin, samples its output once per slot
// and publishes each completed frame as a registered parallel word.
// Optional feature macro: TDM_CHANGE_DET_EN adds a 'changed' strobe that fires
// with frame_done whenever the new word differs from the previous one.

module tdm_scan_demux #(
    parameter int unsigned CH    = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             mux_y,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic [CH-1:0]    d_out,
    output logic             frame_done
`ifdef TDM_CHANGE_DET_EN
    ,
    output logic             changed
`endif
);

    typedef enum logic [0:0] {StIdle, StScan} state_t;

    localparam logic [SEL_W-1:0] LastSel = SEL_W'(CH - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CH-1:0]    shadow_q, shadow_d;
    logic [CH-1:0]    d_out_q, d_out_d;
    logic             frame_done_q, frame_done_d;
    logic             last_slot;

    assign last_slot = (sel_q == LastSel);

    // Next-state: step through slots, capture mux_y, publish on the last slot.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        shadow_d     = shadow_q;
        d_out_d      = d_out_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                sel_d = '0;
                if (start) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                shadow_d[sel_q] = mux_y;
                if (last_slot) begin
                    // Last bit goes straight into d_out so the word lands on this edge.
                    d_out_d         = shadow_q;
                    d_out_d[CH-1]   = mux_y;
                    frame_done_d    = 1'b1;
                    sel_d           = '0;
                    if (!continuous) begin
                        state_d = StIdle;
                    end
                end else begin
                    sel_d = sel_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            shadow_q     <= '0;
            d_out_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            shadow_q     <= shadow_d;
            d_out_q      <= d_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign busy       = (state_q == StScan);
    assign d_out      = d_out_q;
    assign frame_done = frame_done_q;

`ifdef TDM_CHANGE_DET_EN
    logic changed_q, changed_d;

    assign changed_d = frame_done_d && (d_out_d != d_out_q);

    // Change strobe, aligned with frame_done; d_out resets to 0 so the first frame compares to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign changed = changed_q;
`endif

endmodule
